riscv_fetch: RTL and testbench

Instruction fetch stage directly upstream of `riscv_decoder`. It holds the program counter and a word-addressed instruction memory, and registers each fetched instruction with its PC into an IF/ID output register that drives the decoder's `in` port. It supports stall, branch/jump redirect with a one-cycle bubble, and a sticky fault halt for illegal fetch addresses. Memory is loaded through a synchronous write port.

---
 rtl/riscv_fetch_if.sv | 46 ++++
 rtl/riscv_fetch.sv | 119 +++++++++++
 tb/tb_riscv_fetch.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_fetch_if.sv
// Fetch-stage bus: pipeline control, instruction memory load port and IF/ID outputs.
// The master side drives control and load; the slave side (the fetch stage) drives the outputs.
interface riscv_fetch_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        fault;
    logic [31:0] instr_count;

    modport master (
        output stall,
        output redirect,
        output redirect_target,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        input  instr,
        input  pc_out,
        input  pc_plus4,
        input  valid,
        input  fault,
        input  instr_count
    );

    modport slave (
        input  stall,
        input  redirect,
        input  redirect_target,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        output instr,
        output pc_out,
        output pc_plus4,
        output valid,
        output fault,
        output instr_count
    );
endinterface

// File: rtl/riscv_fetch.sv
// Instruction fetch stage: PC, word-addressed instruction memory and IF/ID register.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | first edge after reset release, no fetch, valid stays low
//   RUN   | fetch one word per edge; priority fault > redirect > stall
//   HALT  | sticky fault, outputs frozen until reset
//
// Memory is not reset; the load port writes in any state and ignores
// addresses outside the array. A same-edge write to the word being fetched
// returns the old data because the fetch reads the array before the write
// lands.
module riscv_fetch #(
    parameter int unsigned MEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    riscv_fetch_if.slave  bus
);
    localparam int unsigned AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    logic        r_valid;
    logic        r_fault;
    logic [31:0] r_instr_count;

    logic [31:0] r_mem [MEM_DEPTH];

    logic [AW-1:0] w_fetch_idx;
    logic [AW-1:0] w_wr_idx;
    logic [31:0]   w_fetch_word;
    logic          w_pc_oob;
    logic          w_wr_oob;
    logic          w_mis_redirect;
    logic          w_unused;

    assign w_fetch_idx    = r_pc[AW+1:2];
    assign w_wr_idx       = bus.imem_addr[AW+1:2];
    assign w_fetch_word   = r_mem[w_fetch_idx];
    assign w_pc_oob       = (r_pc[31:AW+2] != '0);
    assign w_wr_oob       = (bus.imem_addr[31:AW+2] != '0);
    assign w_mis_redirect = bus.redirect && (bus.redirect_target[1:0] != 2'b00);

    // byte-offset bits carry no information for word fetches and writes
    assign w_unused = ^{bus.imem_addr[1:0], r_pc[1:0]};

    // instruction memory load port, no reset so contents survive rst
    always_ff @(posedge i_clk) begin
        if (bus.imem_we && !w_wr_oob) begin
            r_mem[w_wr_idx] <= bus.imem_wdata;
        end
    end

    // fetch sequencer and IF/ID output register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= NOP;
            r_pc_out      <= '0;
            r_valid       <= 1'b0;
            r_fault       <= 1'b0;
            r_instr_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (w_mis_redirect || w_pc_oob) begin
                        // pc is left untouched so the offending address stays visible
                        r_state <= HALT;
                        r_fault <= 1'b1;
                        r_valid <= 1'b0;
                        r_instr <= NOP;
                    end else if (bus.redirect) begin
                        r_pc    <= bus.redirect_target;
                        r_valid <= 1'b0;
                        r_instr <= NOP;
                    end else if (!bus.stall) begin
                        r_instr       <= w_fetch_word;
                        r_pc_out      <= r_pc;
                        r_valid       <= 1'b1;
                        r_pc          <= r_pc + 32'd4;
                        r_instr_count <= r_instr_count + 32'd1;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= HALT;
                    r_fault <= 1'b1;
                    r_valid <= 1'b0;
                    r_instr <= NOP;
                end
            endcase
        end
    end

    assign bus.instr       = r_instr;
    assign bus.pc_out      = r_pc_out;
    assign bus.pc_plus4    = r_pc_out + 32'd4;
    assign bus.valid       = r_valid;
    assign bus.fault       = r_fault;
    assign bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_riscv_fetch.sv
// Bench for riscv_fetch: directed scenarios followed by randomized traffic,
// all checked against a cycle-level behavioural model of the fetch stage.
module tb_riscv_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    riscv_fetch_if bus();

    riscv_fetch #(
        .MEM_DEPTH (64),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_started;
    bit          m_halted;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcout;
    logic [31:0] m_cnt;
    bit          m_valid;
    bit          m_fault;
    logic [31:0] m_mem [64];
    logic [31:0] word63;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_halted  = 1'b0;
        m_pc      = 32'h0;
        m_instr   = NOP;
        m_pcout   = 32'h0;
        m_cnt     = 32'h0;
        m_valid   = 1'b0;
        m_fault   = 1'b0;
    endtask

    // one rising edge of the fetch stage as described behaviourally
    task automatic model_edge();
        logic [31:0] fw;
        fw = m_mem[m_pc[7:2]];
        if (rst_n) begin
            if (!m_started) begin
                m_started = 1'b1;
            end else if (!m_halted) begin
                if ((bus.redirect && (bus.redirect_target % 4 != 0)) || (m_pc >= 32'd256)) begin
                    m_halted = 1'b1;
                    m_fault  = 1'b1;
                    m_valid  = 1'b0;
                    m_instr  = NOP;
                end else if (bus.redirect) begin
                    m_pc    = bus.redirect_target;
                    m_valid = 1'b0;
                    m_instr = NOP;
                end else if (!bus.stall) begin
                    m_instr = fw;
                    m_pcout = m_pc;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 4;
                    m_cnt   = m_cnt + 1;
                end
            end
        end
        if (bus.imem_we && (bus.imem_addr < 32'd256)) begin
            m_mem[bus.imem_addr / 4] = bus.imem_wdata;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_instr"}, bus.instr, m_instr);
        chk({tag, "_pc_out"}, bus.pc_out, m_pcout);
        chk({tag, "_pc_plus4"}, bus.pc_plus4, m_pcout + 32'd4);
        chk({tag, "_valid"}, {31'b0, bus.valid}, {31'b0, m_valid});
        chk({tag, "_fault"}, {31'b0, bus.fault}, {31'b0, m_fault});
        chk({tag, "_count"}, bus.instr_count, m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all("cyc");
    endtask

    // assert reset between edges and check the immediate effect
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
    endtask

    task automatic release_rst();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic clear_inputs();
        bus.stall           = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 32'h0;
        bus.imem_we         = 1'b0;
        bus.imem_addr       = 32'h0;
        bus.imem_wdata      = 32'h0;
    endtask

    initial begin
        logic [31:0] w;
        int r;
        clear_inputs();
        model_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = 32'hDEAD_0000;
        #1;
        rst_n = 1'b0;

        // preload the whole array through the load port while in reset
        word63 = $urandom;
        for (int i = 0; i < 64; i++) begin
            case (i)
                0:       w = 32'h0050_0113;
                1:       w = 32'h00C0_0193;
                4:       w = 32'h0471_AA23;
                63:      w = word63;
                default: w = $urandom;
            endcase
            bus.imem_we    = 1'b1;
            bus.imem_addr  = i * 4;
            bus.imem_wdata = w;
            tick();
        end
        bus.imem_we = 1'b0;
        chk("rst_valid", {31'b0, bus.valid}, 32'd0);
        chk("rst_instr", bus.instr, NOP);

        // reset release and first fetches
        release_rst();
        tick();
        chk("idle_valid", {31'b0, bus.valid}, 32'd0);
        chk("idle_instr", bus.instr, NOP);
        tick();
        chk("f0_instr", bus.instr, 32'h0050_0113);
        chk("f0_pc_out", bus.pc_out, 32'h0);
        chk("f0_pc_plus4", bus.pc_plus4, 32'h4);
        tick();
        chk("f1_instr", bus.instr, 32'h00C0_0193);
        chk("f1_pc_out", bus.pc_out, 32'h4);
        chk("f1_count", bus.instr_count, 32'd2);

        // stall holds the output register
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_instr", bus.instr, 32'h00C0_0193);
            chk("stall_pc_out", bus.pc_out, 32'h4);
            chk("stall_count", bus.instr_count, 32'd2);
            chk("stall_valid", {31'b0, bus.valid}, 32'd1);
        end
        bus.stall = 1'b0;
        tick();
        chk("unstall_pc_out", bus.pc_out, 32'h8);
        chk("unstall_count", bus.instr_count, 32'd3);

        // redirect wins over stall and leaves one bubble
        bus.redirect        = 1'b1;
        bus.redirect_target = 32'h10;
        bus.stall           = 1'b1;
        tick();
        chk("redir_valid", {31'b0, bus.valid}, 32'd0);
        chk("redir_instr", bus.instr, NOP);
        bus.redirect = 1'b0;
        bus.stall    = 1'b0;
        tick();
        chk("redir_tgt_instr", bus.instr, 32'h0471_AA23);
        chk("redir_tgt_pc_out", bus.pc_out, 32'h10);

        // misaligned redirect halts
        bus.redirect        = 1'b1;
        bus.redirect_target = 32'h12;
        tick();
        chk("mis_fault", {31'b0, bus.fault}, 32'd1);
        chk("mis_valid", {31'b0, bus.valid}, 32'd0);
        bus.redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_fault", {31'b0, bus.fault}, 32'd1);
            chk("halt_valid", {31'b0, bus.valid}, 32'd0);
            chk("halt_pc_out", bus.pc_out, 32'h10);
            chk("halt_count", bus.instr_count, 32'd4);
        end

        // out-of-range fetch after the last word
        async_reset();
        tick();
        release_rst();
        tick();
        tick();
        bus.redirect        = 1'b1;
        bus.redirect_target = 32'hFC;
        tick();
        bus.redirect = 1'b0;
        tick();
        chk("last_valid", {31'b0, bus.valid}, 32'd1);
        chk("last_pc_out", bus.pc_out, 32'hFC);
        chk("last_instr", bus.instr, word63);
        tick();
        chk("oob_fault", {31'b0, bus.fault}, 32'd1);
        chk("oob_valid", {31'b0, bus.valid}, 32'd0);

        // memory survives reset; read-before-write on the fetched word
        async_reset();
        release_rst();
        tick();
        tick();
        chk("retain_mem0", bus.instr, 32'h0050_0113);
        bus.imem_we    = 1'b1;
        bus.imem_addr  = 32'h4;
        bus.imem_wdata = 32'h0023_E233;
        tick();
        chk("rbw_old", bus.instr, 32'h00C0_0193);
        bus.imem_we = 1'b0;
        tick();

        // reset in the middle of running
        async_reset();
        chk("midrst_valid", {31'b0, bus.valid}, 32'd0);
        chk("midrst_pc_out", bus.pc_out, 32'h0);
        chk("midrst_count", bus.instr_count, 32'd0);
        release_rst();
        tick();
        tick();
        chk("midrst_mem0", bus.instr, 32'h0050_0113);
        bus.redirect        = 1'b1;
        bus.redirect_target = 32'h4;
        tick();
        bus.redirect = 1'b0;
        tick();
        chk("rbw_new", bus.instr, 32'h0023_E233);
        chk("rbw_new_pc", bus.pc_out, 32'h4);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ((m_halted && ($urandom_range(3) == 0)) || ($urandom_range(199) == 0)) begin
                clear_inputs();
                async_reset();
                if ($urandom_range(1) == 1) tick();
                release_rst();
                tick();
            end else begin
                bus.stall    = ($urandom_range(9) < 3);
                bus.redirect = ($urandom_range(19) < 3);
                r = $urandom_range(9);
                if (r < 8)       bus.redirect_target = {24'h0, 6'($urandom), 2'b00};
                else if (r == 8) bus.redirect_target = {24'h0, 6'($urandom), 2'($urandom_range(3, 1))};
                else             bus.redirect_target = 32'hF0 + 4 * $urandom_range(7);
                bus.imem_we    = ($urandom_range(4) == 0);
                bus.imem_addr  = $urandom_range(299);
                bus.imem_wdata = $urandom;
                tick();
            end
        end

        clear_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
